// File: rtl/draw_sprite.sv
// Sprite blitter: walks a SPRITE_W x SPRITE_H sprite from a synchronous ROM and
// emits one clipped, colour-keyed plot request per pixel for the vga_adapter.
module draw_sprite #(
    parameter int SPRITE_W = 16,
    parameter int SPRITE_H = 16,
    parameter int ADDR_W = 8,
    parameter int COLOUR_W = 8,
    parameter logic [COLOUR_W-1:0] TRANSPARENT = 8'hE3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          xPos,
    input  logic [6:0]          yPos,
    output logic [ADDR_W-1:0]   romAddr,
    input  logic [COLOUR_W-1:0] romData,
    output logic [7:0]          xOut,
    output logic [6:0]          yOut,
    output logic [COLOUR_W-1:0] colour,
    output logic                writeEn,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cx_q, cx_d;
    logic [6:0]          cy_q, cy_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          x_lat_q, x_lat_d;
    logic [6:0]          y_lat_q, y_lat_d;
    logic                valid_q, valid_d;
    logic                clip_q, clip_d;
    logic [7:0]          x_out_q, x_out_d;
    logic [6:0]          y_out_q, y_out_d;
    logic [8:0]          x_sum;
    logic [7:0]          y_sum;

    // Sums are one bit wider than the screen coordinates so off-screen pixels are detectable.
    assign x_sum = {1'b0, x_lat_q} + {1'b0, cx_q};
    assign y_sum = {1'b0, y_lat_q} + {1'b0, cy_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            addr_q  <= '0;
            x_lat_q <= '0;
            y_lat_q <= '0;
            valid_q <= 1'b0;
            clip_q  <= 1'b0;
            x_out_q <= '0;
            y_out_q <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            addr_q  <= addr_d;
            x_lat_q <= x_lat_d;
            y_lat_q <= y_lat_d;
            valid_q <= valid_d;
            clip_q  <= clip_d;
            x_out_q <= x_out_d;
            y_out_q <= y_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        addr_d  = addr_q;
        x_lat_d = x_lat_q;
        y_lat_d = y_lat_q;
        valid_d = 1'b0;
        clip_d  = clip_q;
        x_out_d = x_out_q;
        y_out_d = y_out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_lat_d = xPos;
                    y_lat_d = yPos;
                    cx_d    = '0;
                    cy_d    = '0;
                    addr_d  = '0;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                // Register the coordinates of the pixel whose ROM data returns next cycle.
                valid_d = 1'b1;
                x_out_d = x_sum[7:0];
                y_out_d = y_sum[6:0];
                clip_d  = (x_sum >= 9'd160) || (y_sum >= 8'd120);
                addr_d  = addr_q + ADDR_W'(1);
                cx_d    = cx_q + 8'd1;
                if (cx_q == 8'(SPRITE_W - 1)) begin
                    cx_d = '0;
                    cy_d = cy_q + 7'd1;
                    if (cy_q == 7'(SPRITE_H - 1)) begin
                        cy_d    = '0;
                        addr_d  = '0;
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign romAddr = addr_q;
    assign xOut    = x_out_q;
    assign yOut    = y_out_q;
    assign colour  = romData;
    assign writeEn = valid_q & ~clip_q & (romData != TRANSPARENT);
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_draw_sprite.sv
// Directed bench for draw_sprite: a 4x2 instance for timing, keying, clipping,
// back-to-back and abort cases, and a default 16x16 instance for a full sweep.
module tb_draw_sprite;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       start16 = 1'b0;
    logic [7:0] x_pos = 8'd0;
    logic [6:0] y_pos = 7'd0;

    logic [2:0] rom_addr;
    logic [7:0] rom_data = 8'h00;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [7:0] colour;
    logic       write_en, busy, done;

    logic [7:0] rom_addr16;
    logic [7:0] rom_data16 = 8'h00;
    logic [7:0] x_out16;
    logic [6:0] y_out16;
    logic [7:0] colour16;
    logic       write_en16, busy16, done16;

    logic [7:0] rom [0:7];
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_data   <= rom[rom_addr];
        rom_data16 <= 8'h1C;
    end

    draw_sprite #(.SPRITE_W(4), .SPRITE_H(2), .ADDR_W(3), .COLOUR_W(8), .TRANSPARENT(8'hE3)) dut (
        .clk(clk), .reset(reset), .start(start), .xPos(x_pos), .yPos(y_pos),
        .romAddr(rom_addr), .romData(rom_data), .xOut(x_out), .yOut(y_out),
        .colour(colour), .writeEn(write_en), .busy(busy), .done(done)
    );

    draw_sprite dut16 (
        .clk(clk), .reset(reset), .start(start16), .xPos(x_pos), .yPos(y_pos),
        .romAddr(rom_addr16), .romData(rom_data16), .xOut(x_out16), .yOut(y_out16),
        .colour(colour16), .writeEn(write_en16), .busy(busy16), .done(done16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge of the idle cycle after done.
    task automatic run_blit(input int x, input int y, input int exp_writes, input bit hold);
        int writes;
        int busy_n;
        int k;
        int xs;
        int ys;
        bit ew;
        writes = 0;
        busy_n = 0;
        start = 1'b1;
        x_pos = 8'(x);
        y_pos = 7'(y);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = hold;
                x_pos = 8'd77;
                y_pos = 7'd5;
            end
            busy_n += 32'(busy);
            writes += 32'(write_en);
            if (c <= 8) chk("rom_addr", 32'(rom_addr), 32'(c - 1));
            if (c >= 2 && c <= 9) begin
                k  = c - 2;
                xs = x + k % 4;
                ys = y + k / 4;
                ew = (xs < 160) && (ys < 120) && (rom[k] != 8'hE3);
                chk("write_en", 32'(write_en), 32'(ew));
                if (ew) begin
                    chk("x_out", 32'(x_out), 32'(xs[7:0]));
                    chk("y_out", 32'(y_out), 32'(ys[6:0]));
                    chk("colour", 32'(colour), 32'(rom[k]));
                end
            end else begin
                chk("write_en_off", 32'(write_en), 32'(0));
            end
            chk("done", 32'(done), 32'(c == 10));
        end
        chk("busy_cycles", 32'(busy_n), 32'(10));
        chk("write_count", 32'(writes), 32'(exp_writes));
    endtask

    initial begin
        int done_seen;
        int writes16;
        int done_at;
        logic [7:0] last_x;
        logic [6:0] last_y;
        for (int i = 0; i < 8; i++) rom[i] = 8'(i + 1);

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_we", 32'(write_en), 32'(0));
        chk("rst_x", 32'(x_out), 32'(0));
        chk("rst_y", 32'(y_out), 32'(0));
        chk("rst_addr", 32'(rom_addr), 32'(0));
        chk("rst_busy16", 32'(busy16), 32'(0));
        chk("rst_addr16", 32'(rom_addr16), 32'(0));
        reset = 1'b0;
        @(negedge clk);

        // Plain blit, 8 writes.
        run_blit(10, 20, 8, 1'b0);

        // Colour key on pixels 2 and 5.
        rom[2] = 8'hE3;
        rom[5] = 8'hE3;
        run_blit(10, 20, 6, 1'b0);
        rom[2] = 8'h03;
        rom[5] = 8'h06;

        // Clipping at the bottom-right corner: only (158,119) and (159,119).
        run_blit(158, 119, 2, 1'b0);

        // start held high: back-to-back blits separated by one idle cycle.
        run_blit(30, 40, 8, 1'b1);
        run_blit(50, 60, 8, 1'b1);
        start = 1'b0;
        @(negedge clk);
        chk("held_stop_busy", 32'(busy), 32'(0));

        // Abort on the third DRAW cycle.
        start = 1'b1;
        x_pos = 8'd10;
        y_pos = 7'd20;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort_pre_we", 32'(write_en), 32'(1));
        chk("abort_pre_x", 32'(x_out), 32'(10));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_we", 32'(write_en), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_x", 32'(x_out), 32'(0));
        chk("abort_y", 32'(y_out), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            done_seen += 32'(done) + 32'(write_en);
        end
        chk("abort_quiet", 32'(done_seen), 32'(0));
        run_blit(10, 20, 8, 1'b0);

        // Default 16x16 sprite at the origin.
        writes16 = 0;
        done_at = 0;
        last_x = 8'd0;
        last_y = 7'd0;
        x_pos = 8'd0;
        y_pos = 7'd0;
        start16 = 1'b1;
        for (int c = 1; c <= 259; c++) begin
            @(negedge clk);
            if (c == 1) start16 = 1'b0;
            if (c <= 256) chk("addr16", 32'(rom_addr16), 32'(c - 1));
            if (write_en16) begin
                writes16++;
                last_x = x_out16;
                last_y = y_out16;
            end
            if (done16) done_at = c;
        end
        chk("writes16", 32'(writes16), 32'(256));
        chk("last_x16", 32'(last_x), 32'(15));
        chk("last_y16", 32'(last_y), 32'(15));
        chk("done_at16", 32'(done_at), 32'(258));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/draw_sprite.md
Name: draw_sprite

Overview:
- Sprite blitter that sits upstream of the vga_adapter, alongside the full-screen draw modules. On a start pulse it walks a SPRITE_W x SPRITE_H sprite stored in an external synchronous ROM.
- Each opaque pixel becomes one plot request (xOut, yOut, colour, writeEn) at screen offset (xPos, yPos), clipped to the 160x120 frame.
- It reports completion with a one-cycle done pulse. The top level muxes its outputs onto the adapter by location, the same way as the other draw modules.

Parameters:
- SPRITE_W, 16, sprite width in pixels (1..160)
- SPRITE_H, 16, sprite height in pixels (1..120)
- ADDR_W, 8, ROM address width; must satisfy 2^ADDR_W >= SPRITE_W*SPRITE_H
- COLOUR_W, 8, colour width, matching the draw-module colour bus
- TRANSPARENT, 8'hE3, colour key; pixels equal to it are never plotted

Ports:
- clk  input  1  system clock (CLOCK_50)
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a blit; sampled only in IDLE
- xPos  input  8  sprite top-left x; latched on accepted start
- yPos  input  7  sprite top-left y; latched on accepted start
- romAddr  output  ADDR_W  sprite ROM address, row-major (cy*SPRITE_W + cx)
- romData  input  COLOUR_W  ROM read data, valid exactly one cycle after romAddr
- xOut  output  8  plot x (registered)
- yOut  output  7  plot y (registered)
- colour  output  COLOUR_W  plot colour (equals romData)
- writeEn  output  1  plot strobe to the vga_adapter
- busy  output  1  high whenever the state is not IDLE
- done  output  1  one-cycle completion pulse

Behaviour:
- States: IDLE, DRAW, FLUSH, DONE. Let N = SPRITE_W*SPRITE_H.
- Reset, synchronous and taking priority over everything:
  - state=IDLE; cx=cy=0; pipeline valid=0
  - xOut=0, yOut=0, writeEn=0, busy=0, done=0, romAddr=0
  - Reset asserted mid-blit aborts it: no further writeEn, and no done pulse.
- IDLE + start=1: latch xPos/yPos, clear cx/cy, go to DRAW. start in any other state is ignored; it is not queued.
- DRAW:
  - Each cycle, romAddr = cy*SPRITE_W + cx, then advance cx.
  - When cx = SPRITE_W-1, wrap cx to 0 and increment cy.
  - After the cycle with cx = SPRITE_W-1 and cy = SPRITE_H-1, go to FLUSH. DRAW lasts exactly N cycles.
- Pipeline, one stage:
  - At the end of each DRAW cycle, register valid=1, xOut = xLatch+cx, yOut = yLatch+cy.
  - Compute the sums at 9 bits (x) and 8 bits (y); store clip flag = (x sum >= 160) or (y sum >= 120).
  - xOut/yOut take the truncated low bits.
  - valid clears at the end of the FLUSH cycle.
- writeEn = valid & ~clip & (romData != TRANSPARENT). This is combinational on romData; colour = romData.
- Timing: pixel k (0..N-1) is presented in the cycle after its address cycle, so the last pixel is presented during FLUSH.
- FLUSH: one cycle, then DONE.
- DONE: done=1 for exactly one cycle, then IDLE. A start during DONE is ignored.
- Blit length: start-accept edge to return to IDLE is N+2 cycles; busy is high for all N+2.
- At most one writeEn per sprite pixel; clipped or transparent pixels still consume their cycle, so timing is data-independent.
- xPos/yPos changes during a blit have no effect.

Test Plan:
- SPRITE_W=4, SPRITE_H=2, ROM = 0x01..0x08, xPos=10, yPos=20, start for 1 cycle -> 8 consecutive writeEn cycles beginning 2 cycles after start is sampled. Coordinates (10,20)..(13,20), (10,21)..(13,21); colours 0x01..0x08; done pulses the cycle after the last write; busy high for 10 cycles.
- Same setup but ROM[2]=ROM[5]=8'hE3 -> writeEn low in the 3rd and 6th pixel slots, 6 writes total, done timing unchanged.
- xPos=158, yPos=119 -> only (158,119) and (159,119) are written; all pixels with x>=160 or y>=120 are suppressed; done still arrives after N+1 cycles.
- start held high continuously -> blits run back-to-back with exactly one idle cycle between done and the next DRAW; start during DRAW/FLUSH/DONE does not restart the blit or change xOut.
- reset asserted on the 3rd DRAW cycle -> next cycle writeEn=0, busy=0, xOut=yOut=0, no done pulse; a subsequent start runs a full, correct blit.
- Default 16x16 with an all-0x1C ROM at (0,0) -> 256 writes, romAddr sequences 0..255, last write at (15,15).
